// File: rtl/mem_bus_arbiter.sv
// Merges the instruction and data buses onto one memory port. A small owner FIFO
// remembers which master issued each outstanding command so in-order responses route back.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_PENDING   = 2,
    parameter bit DBUS_PRIORITY = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          ibus_cmd_valid,
    output logic                          ibus_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]         ibus_cmd_payload_address,
    output logic                          ibus_rsp_valid,
    input  logic                          ibus_rsp_ready,
    output logic [DATA_WIDTH-1:0]         ibus_rsp_payload_rdata,

    input  logic                          dbus_cmd_valid,
    output logic                          dbus_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]         dbus_cmd_payload_address,
    input  logic                          dbus_cmd_payload_write,
    input  logic [DATA_WIDTH-1:0]         dbus_cmd_payload_wdata,
    input  logic [DATA_WIDTH/8-1:0]       dbus_cmd_payload_wmask,
    output logic                          dbus_rsp_valid,
    input  logic                          dbus_rsp_ready,
    output logic [DATA_WIDTH-1:0]         dbus_rsp_payload_rdata,

    output logic                          mem_cmd_valid,
    input  logic                          mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0]         mem_cmd_payload_address,
    output logic                          mem_cmd_payload_write,
    output logic [DATA_WIDTH-1:0]         mem_cmd_payload_wdata,
    output logic [DATA_WIDTH/8-1:0]       mem_cmd_payload_wmask,
    input  logic                          mem_rsp_valid,
    output logic                          mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]         mem_rsp_payload_rdata,

    output logic [$clog2(MAX_PENDING):0]  pending
);

    localparam int PTR_WIDTH = $clog2(MAX_PENDING);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    typedef enum logic {
        OWNER_IBUS = 1'b0,
        OWNER_DBUS = 1'b1
    } owner_e;

    owner_e                 owner_fifo [MAX_PENDING];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [CNT_WIDTH-1:0]   count;
    logic                   lock;
    owner_e                 lock_owner;
    owner_e                 last_grant;
    owner_e                 grant;
    owner_e                 head;
    logic                   full;
    logic                   empty;
    logic                   cmd_fire;
    logic                   rsp_fire;

    assign full  = (count == CNT_WIDTH'(MAX_PENDING));
    assign empty = (count == '0);
    assign head  = owner_fifo[rd_ptr];

    // A stalled command keeps its master until it fires, so the payload cannot change under backpressure.
    always_comb begin
        if (lock) begin
            grant = lock_owner;
        end else if (dbus_cmd_valid && !ibus_cmd_valid) begin
            grant = OWNER_DBUS;
        end else if (ibus_cmd_valid && !dbus_cmd_valid) begin
            grant = OWNER_IBUS;
        end else if (ibus_cmd_valid && dbus_cmd_valid) begin
            if (DBUS_PRIORITY || last_grant == OWNER_IBUS) grant = OWNER_DBUS;
            else                                           grant = OWNER_IBUS;
        end else begin
            grant = OWNER_IBUS;
        end
    end

    // Readiness depends only on registered occupancy, never on the response side.
    assign mem_cmd_valid  = reset && (ibus_cmd_valid || dbus_cmd_valid) && !full;
    assign ibus_cmd_ready = reset && (grant == OWNER_IBUS) && mem_cmd_ready && !full;
    assign dbus_cmd_ready = reset && (grant == OWNER_DBUS) && mem_cmd_ready && !full;

    assign mem_cmd_payload_address = (grant == OWNER_DBUS) ? dbus_cmd_payload_address
                                                           : ibus_cmd_payload_address;
    assign mem_cmd_payload_write   = (grant == OWNER_DBUS) && dbus_cmd_payload_write;
    assign mem_cmd_payload_wdata   = (grant == OWNER_DBUS) ? dbus_cmd_payload_wdata : '0;
    assign mem_cmd_payload_wmask   = (grant == OWNER_DBUS) ? dbus_cmd_payload_wmask : '0;

    assign ibus_rsp_valid = reset && mem_rsp_valid && !empty && (head == OWNER_IBUS);
    assign dbus_rsp_valid = reset && mem_rsp_valid && !empty && (head == OWNER_DBUS);
    assign mem_rsp_ready  = reset && !empty &&
                            ((head == OWNER_DBUS) ? dbus_rsp_ready : ibus_rsp_ready);

    assign ibus_rsp_payload_rdata = mem_rsp_payload_rdata;
    assign dbus_rsp_payload_rdata = mem_rsp_payload_rdata;

    assign pending  = reset ? count : '0;
    assign cmd_fire = mem_cmd_valid && mem_cmd_ready;
    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lock       <= 1'b0;
            lock_owner <= OWNER_IBUS;
            last_grant <= OWNER_IBUS;
        end else begin
            if (cmd_fire) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (rsp_fire) rd_ptr <= rd_ptr + PTR_WIDTH'(1);

            case ({cmd_fire, rsp_fire})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase

            if (cmd_fire) begin
                lock       <= 1'b0;
                last_grant <= grant;
            end else if (mem_cmd_valid && !mem_cmd_ready) begin
                lock       <= 1'b1;
                lock_owner <= grant;
            end
        end
    end

    // NOTE: the owner storage is deliberately not reset; an entry is only read while
    // count says it is valid, and reset clears count and both pointers.
    always_ff @(posedge clk) begin
        if (cmd_fire) owner_fifo[wr_ptr] <= grant;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised scoreboard bench for mem_bus_arbiter: a queue-based reference of the
// arbitration rules predicts every handshake, memory command and routed response.
module tb_mem_bus_arbiter;

    localparam int MP = 2;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  rdy;
    } rr_cmd_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main DUT (dbus priority)
    logic        ibus_cmd_valid, ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_ready;
    logic [31:0] ibus_cmd_payload_address, ibus_rsp_payload_rdata;
    logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_payload_write, dbus_rsp_valid, dbus_rsp_ready;
    logic [31:0] dbus_cmd_payload_address, dbus_cmd_payload_wdata, dbus_rsp_payload_rdata;
    logic [3:0]  dbus_cmd_payload_wmask;
    logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_payload_write, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_cmd_payload_address, mem_cmd_payload_wdata, mem_rsp_payload_rdata;
    logic [3:0]  mem_cmd_payload_wmask;
    logic [1:0]  pending;

    // Round-robin DUT
    logic        r_ibus_cmd_valid, r_ibus_cmd_ready, r_ibus_rsp_valid, r_ibus_rsp_ready;
    logic [31:0] r_ibus_cmd_payload_address, r_ibus_rsp_payload_rdata;
    logic        r_dbus_cmd_valid, r_dbus_cmd_ready, r_dbus_cmd_payload_write, r_dbus_rsp_valid, r_dbus_rsp_ready;
    logic [31:0] r_dbus_cmd_payload_address, r_dbus_cmd_payload_wdata, r_dbus_rsp_payload_rdata;
    logic [3:0]  r_dbus_cmd_payload_wmask;
    logic        r_mem_cmd_valid, r_mem_cmd_ready, r_mem_cmd_payload_write, r_mem_rsp_valid, r_mem_rsp_ready;
    logic [31:0] r_mem_cmd_payload_address, r_mem_cmd_payload_wdata, r_mem_rsp_payload_rdata;
    logic [3:0]  r_mem_cmd_payload_wmask;
    logic [1:0]  r_pending;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_PENDING(MP), .DBUS_PRIORITY(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
        .ibus_cmd_payload_address(ibus_cmd_payload_address),
        .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_ready(ibus_rsp_ready),
        .ibus_rsp_payload_rdata(ibus_rsp_payload_rdata),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_cmd_payload_address(dbus_cmd_payload_address), .dbus_cmd_payload_write(dbus_cmd_payload_write),
        .dbus_cmd_payload_wdata(dbus_cmd_payload_wdata), .dbus_cmd_payload_wmask(dbus_cmd_payload_wmask),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_ready(dbus_rsp_ready),
        .dbus_rsp_payload_rdata(dbus_rsp_payload_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_payload_address(mem_cmd_payload_address), .mem_cmd_payload_write(mem_cmd_payload_write),
        .mem_cmd_payload_wdata(mem_cmd_payload_wdata), .mem_cmd_payload_wmask(mem_cmd_payload_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_payload_rdata(mem_rsp_payload_rdata),
        .pending(pending)
    );

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_PENDING(MP), .DBUS_PRIORITY(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .ibus_cmd_valid(r_ibus_cmd_valid), .ibus_cmd_ready(r_ibus_cmd_ready),
        .ibus_cmd_payload_address(r_ibus_cmd_payload_address),
        .ibus_rsp_valid(r_ibus_rsp_valid), .ibus_rsp_ready(r_ibus_rsp_ready),
        .ibus_rsp_payload_rdata(r_ibus_rsp_payload_rdata),
        .dbus_cmd_valid(r_dbus_cmd_valid), .dbus_cmd_ready(r_dbus_cmd_ready),
        .dbus_cmd_payload_address(r_dbus_cmd_payload_address), .dbus_cmd_payload_write(r_dbus_cmd_payload_write),
        .dbus_cmd_payload_wdata(r_dbus_cmd_payload_wdata), .dbus_cmd_payload_wmask(r_dbus_cmd_payload_wmask),
        .dbus_rsp_valid(r_dbus_rsp_valid), .dbus_rsp_ready(r_dbus_rsp_ready),
        .dbus_rsp_payload_rdata(r_dbus_rsp_payload_rdata),
        .mem_cmd_valid(r_mem_cmd_valid), .mem_cmd_ready(r_mem_cmd_ready),
        .mem_cmd_payload_address(r_mem_cmd_payload_address), .mem_cmd_payload_write(r_mem_cmd_payload_write),
        .mem_cmd_payload_wdata(r_mem_cmd_payload_wdata), .mem_cmd_payload_wmask(r_mem_cmd_payload_wmask),
        .mem_rsp_valid(r_mem_rsp_valid), .mem_rsp_ready(r_mem_rsp_ready),
        .mem_rsp_payload_rdata(r_mem_rsp_payload_rdata),
        .pending(r_pending)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: outstanding owners in issue order, stalled master, last winner.
    bit   owner_q [$];
    int   stall = -1;
    bit   last  = 1'b0;
    cmd_t cmd_q [$];
    rsp_t rsp_q [$];

    // Bench-side masters and memory
    bit          i_busy, d_busy, d_write, rsp_busy, fixed_en;
    logic [31:0] i_addr, d_addr, d_wdata, rsp_data, fixed_rdata;
    logic [3:0]  d_wmask;
    int          i_rate, d_rate, mr_rate, rsp_rate, rr_rate, stray_rate;

    logic [7:0] exp_hs, hs_mask, act_hs;
    bit         hs_en = 1'b0;
    assign act_hs = {mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, mem_rsp_ready,
                     ibus_rsp_valid, dbus_rsp_valid, pending};

    function automatic bit roll(input int rate);
        return $urandom_range(0, 99) < rate;
    endfunction

    task automatic step(input logic rst_val);
        bit   iv, dv, full, empty, g, head, e_mcv, c_fire, e_ir, e_dr, e_mrr, e_irv, e_drv, r_fire, stray;
        cmd_t c;
        rsp_t r;
        reset = rst_val;
        if (!rst_val) begin
            owner_q.delete();
            stall    = -1;
            last     = 1'b0;
            rsp_busy = 1'b0;
        end
        if (!i_busy && roll(i_rate)) begin
            i_busy = 1'b1;
            i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_busy && roll(d_rate)) begin
            d_busy  = 1'b1;
            d_addr  = $urandom & 32'hFFFF_FFFC;
            d_write = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            d_wmask = 4'($urandom_range(0, 15));
        end
        ibus_cmd_valid           = i_busy;
        ibus_cmd_payload_address = i_addr;
        dbus_cmd_valid           = d_busy;
        dbus_cmd_payload_address = d_addr;
        dbus_cmd_payload_write   = d_write;
        dbus_cmd_payload_wdata   = d_wdata;
        dbus_cmd_payload_wmask   = d_wmask;
        mem_cmd_ready            = roll(mr_rate);
        if (!rsp_busy && owner_q.size() != 0 && roll(rsp_rate)) begin
            rsp_busy = 1'b1;
            rsp_data = fixed_en ? fixed_rdata : $urandom;
        end
        stray                 = !rsp_busy && owner_q.size() == 0 && roll(stray_rate);
        mem_rsp_valid         = rsp_busy || stray;
        mem_rsp_payload_rdata = rsp_busy ? rsp_data : $urandom;
        ibus_rsp_ready        = roll(rr_rate);
        dbus_rsp_ready        = roll(rr_rate);

        // Reference: grant rules, capacity, in-order owner routing.
        iv    = i_busy;
        dv    = d_busy;
        full  = owner_q.size() == MP;
        empty = owner_q.size() == 0;
        if (stall >= 0)     g = (stall == 1);
        else if (iv && !dv) g = 1'b0;
        else if (dv && !iv) g = 1'b1;
        else                g = iv && dv;
        e_mcv  = rst_val && (iv || dv) && !full;
        c_fire = e_mcv && mem_cmd_ready;
        e_ir   = rst_val && !g && mem_cmd_ready && !full;
        e_dr   = rst_val &&  g && mem_cmd_ready && !full;
        head   = empty ? 1'b0 : owner_q[0];
        e_mrr  = rst_val && !empty && (head ? dbus_rsp_ready : ibus_rsp_ready);
        e_irv  = rst_val && mem_rsp_valid && !empty && !head;
        e_drv  = rst_val && mem_rsp_valid && !empty &&  head;
        r_fire = mem_rsp_valid && e_mrr;
        exp_hs  = {e_mcv, e_ir, e_dr, e_mrr, e_irv, e_drv, rst_val ? 2'(owner_q.size()) : 2'd0};
        hs_mask = (iv || dv || !rst_val) ? 8'hFF : 8'b1001_1111;
        if (c_fire) begin
            c.write = g ? d_write : 1'b0;
            c.addr  = g ? d_addr  : i_addr;
            c.wdata = g ? d_wdata : 32'd0;
            c.wmask = g ? d_wmask : 4'd0;
            cmd_q.push_back(c);
        end
        if (r_fire) begin
            r.owner = head;
            r.rdata = mem_rsp_payload_rdata;
            rsp_q.push_back(r);
        end
        hs_en = 1'b1;
        if (!rst_val) begin
            #1;
            check("reset_outputs", act_hs, 8'd0);
        end
        @(posedge clk);
        if (r_fire) begin
            void'(owner_q.pop_front());
            rsp_busy = 1'b0;
        end
        if (c_fire) begin
            owner_q.push_back(g);
            last  = g;
            stall = -1;
            if (g) d_busy = 1'b0;
            else   i_busy = 1'b0;
        end else if (e_mcv) begin
            stall = g;
        end
        #1;
    endtask

    task automatic set_rates(input int ir, input int dr, input int mr, input int rs, input int rr, input int st);
        i_rate = ir; d_rate = dr; mr_rate = mr; rsp_rate = rs; rr_rate = rr; stray_rate = st;
    endtask

    task automatic drain(input int max_cycles);
        set_rates(0, 0, 100, 100, 100, 0);
        for (int n = 0; n < max_cycles && (i_busy || d_busy || owner_q.size() != 0); n++) step(1'b1);
        check("drain_idle", {i_busy, d_busy, owner_q.size() != 0}, 3'b000);
    endtask

    task automatic load_i(input logic [31:0] a);
        i_busy = 1'b1; i_addr = a;
    endtask

    task automatic load_d(input logic [31:0] a, input bit w, input logic [31:0] wd, input logic [3:0] wm);
        d_busy = 1'b1; d_addr = a; d_write = w; d_wdata = wd; d_wmask = wm;
    endtask

    cmd_t mon_c;
    rsp_t mon_r;
    initial forever begin
        @(negedge clk);
        if (hs_en) begin
            check("handshake", act_hs & hs_mask, exp_hs & hs_mask);
            if (mem_cmd_valid && mem_cmd_ready) begin
                check("cmd_expected", cmd_q.size() != 0, 1'b1);
                if (cmd_q.size() != 0) begin
                    mon_c = cmd_q.pop_front();
                    check("mem_cmd", {mem_cmd_payload_write, mem_cmd_payload_address,
                                      mem_cmd_payload_wdata, mem_cmd_payload_wmask}, mon_c);
                end
            end
            if ((ibus_rsp_valid && ibus_rsp_ready) || (dbus_rsp_valid && dbus_rsp_ready)) begin
                check("rsp_expected", rsp_q.size() != 0, 1'b1);
                if (rsp_q.size() != 0) begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_route", {dbus_rsp_valid, dbus_rsp_valid ? dbus_rsp_payload_rdata
                                                                       : ibus_rsp_payload_rdata}, mon_r);
                end
            end
        end
    end

    // Round-robin scoreboard
    rr_cmd_t rr_q  [$];
    rsp_t    rrs_q [$];
    bit      rr_en = 1'b0;
    rr_cmd_t rr_c;
    rsp_t    rr_r;
    initial forever begin
        @(negedge clk);
        if (rr_en) begin
            if (r_mem_cmd_valid && r_mem_cmd_ready) begin
                check("rr_cmd_expected", rr_q.size() != 0, 1'b1);
                if (rr_q.size() != 0) begin
                    rr_c = rr_q.pop_front();
                    check("rr_grant", {r_mem_cmd_payload_address, r_mem_cmd_payload_write, r_mem_cmd_payload_wdata,
                                       r_mem_cmd_payload_wmask, r_ibus_cmd_ready, r_dbus_cmd_ready}, rr_c);
                end
            end
            if (r_ibus_rsp_valid || r_dbus_rsp_valid) begin
                check("rr_rsp_expected", rrs_q.size() != 0, 1'b1);
                if (rrs_q.size() != 0) begin
                    rr_r = rrs_q.pop_front();
                    check("rr_rsp_route", {r_ibus_rsp_valid, r_dbus_rsp_valid, r_mem_rsp_ready,
                                           r_dbus_rsp_valid ? r_dbus_rsp_payload_rdata : r_ibus_rsp_payload_rdata},
                          {!rr_r.owner, rr_r.owner, 1'b1, rr_r.rdata});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        bit   rr_last, g;
        rsp_t pr;
        reset = 1'b0;
        {ibus_cmd_valid, ibus_rsp_ready, dbus_cmd_valid, dbus_cmd_payload_write, dbus_rsp_ready} = '0;
        {mem_cmd_ready, mem_rsp_valid} = '0;
        ibus_cmd_payload_address = '0; dbus_cmd_payload_address = '0; dbus_cmd_payload_wdata = '0;
        dbus_cmd_payload_wmask = '0; mem_rsp_payload_rdata = '0;
        {i_busy, d_busy, d_write, rsp_busy, fixed_en} = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; rsp_data = '0; fixed_rdata = '0;
        set_rates(0, 0, 0, 0, 0, 0);
        {r_ibus_cmd_valid, r_ibus_rsp_ready, r_dbus_cmd_valid, r_dbus_rsp_ready, r_mem_cmd_ready, r_mem_rsp_valid} = '0;
        r_ibus_cmd_payload_address = 32'h100;
        r_dbus_cmd_payload_address = 32'h2000;
        r_dbus_cmd_payload_write   = 1'b1;
        r_dbus_cmd_payload_wdata   = 32'h55AA_55AA;
        r_dbus_cmd_payload_wmask   = 4'hF;
        r_mem_rsp_payload_rdata    = '0;
        repeat (2) @(posedge clk);
        #1;

        // Round-robin: both masters held valid for four fires; winner alternates from dbus.
        reset   = 1'b1;
        rr_en   = 1'b1;
        rr_last = 1'b0;
        g       = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            r_ibus_cmd_valid = (k < 4);
            r_dbus_cmd_valid = (k < 4);
            r_mem_cmd_ready  = 1'b1;
            r_mem_rsp_valid  = (k > 0);
            r_mem_rsp_payload_rdata = 32'hA000_0000 + 32'(k);
            r_ibus_rsp_ready = 1'b1;
            r_dbus_rsp_ready = 1'b1;
            if (k > 0) begin
                pr.owner = g;
                pr.rdata = r_mem_rsp_payload_rdata;
                rrs_q.push_back(pr);
            end
            if (k < 4) begin
                g = !rr_last;
                rr_q.push_back(g ? {32'h2000, 1'b1, 32'h55AA_55AA, 4'hF, 2'b01}
                                 : {32'h100, 1'b0, 32'h0, 4'h0, 2'b10});
                rr_last = g;
            end
            @(posedge clk);
            #1;
        end
        {r_ibus_cmd_valid, r_dbus_cmd_valid, r_mem_rsp_valid} = '0;
        rr_en = 1'b0;
        check("rr_scoreboard_empty", 32'(rr_q.size() + rrs_q.size()), 32'd0);
        check("rr_pending_idle", r_pending, 2'd0);

        // Reset held with both masters requesting: everything must read idle.
        set_rates(0, 0, 100, 100, 100, 100);
        load_i(32'h0000_0040);
        load_d(32'h0000_0080, 1'b0, 32'h0, 4'h0);
        repeat (3) step(1'b0);
        drain(20);

        // Single ibus read returning 0xDEADBEEF.
        fixed_en    = 1'b1;
        fixed_rdata = 32'hDEAD_BEEF;
        load_i(32'h100);
        repeat (3) step(1'b1);
        fixed_en = 1'b0;
        drain(20);

        // Tie: dbus store wins, ibus follows; responses return dbus then ibus.
        load_i(32'h104);
        load_d(32'h2000, 1'b1, 32'h1234_5678, 4'hF);
        repeat (6) step(1'b1);
        drain(20);

        // Backpressure: ibus stalls first, dbus arrives; grant stays with ibus.
        set_rates(0, 0, 0, 100, 100, 0);
        load_i(32'h300);
        step(1'b1);
        load_d(32'h400, 1'b1, 32'hCAFE_F00D, 4'h3);
        repeat (3) step(1'b1);
        drain(20);

        // Backpressure with dbus winning and ibus raised during the stall.
        set_rates(0, 0, 0, 100, 100, 0);
        load_d(32'h500, 1'b0, 32'h0, 4'h0);
        step(1'b1);
        load_i(32'h600);
        repeat (2) step(1'b1);
        drain(20);

        // Full FIFO: two outstanding, third blocked; response and command in the same cycle.
        set_rates(0, 0, 100, 0, 100, 0);
        load_i(32'h700);
        load_d(32'h800, 1'b1, 32'h0BAD_F00D, 4'hC);
        repeat (2) step(1'b1);
        load_i(32'h900);
        repeat (2) step(1'b1);
        rsp_rate = 100;
        repeat (4) step(1'b1);
        drain(20);

        // Randomised traffic with varying rates.
        for (int blk = 0; blk < 30; blk++) begin
            set_rates($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(10, 100),
                      $urandom_range(10, 100), $urandom_range(20, 100), $urandom_range(0, 20));
            repeat (100) step(1'b1);
        end
        drain(50);

        // Reset mid-flight at pending=2, then stray responses after release.
        set_rates(0, 0, 100, 0, 100, 0);
        load_i(32'hA00);
        load_d(32'hB00, 1'b0, 32'h0, 4'h0);
        for (int n = 0; n < 10 && owner_q.size() != MP; n++) step(1'b1);
        check("reached_full", 32'(owner_q.size()), 32'(MP));
        set_rates(0, 0, 100, 0, 100, 100);
        load_i(32'hC00);
        repeat (2) step(1'b0);
        set_rates(0, 0, 0, 0, 100, 100);
        repeat (3) step(1'b1);
        drain(20);

        check("scoreboard_empty", 32'(cmd_q.size() + rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
